// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared widths, opcodes and FSM encoding for alu_arbiter
package alu_arbiter_pkg;

   localparam int ALU_DATA_WIDTH = 32;
   localparam int ALU_OPRN_WIDTH = 6;

   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h20;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h22;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h2C;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SRL = 6'h02;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLL = 6'h01;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h24;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h25;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h27;
   localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } alu_arb_state_e;

   function automatic logic alu_oprn_legal(input logic [ALU_OPRN_WIDTH-1:0] oprn);
      case (oprn)
         ALU_OPRN_ADD, ALU_OPRN_SUB, ALU_OPRN_MUL, ALU_OPRN_SRL, ALU_OPRN_SLL,
         ALU_OPRN_AND, ALU_OPRN_OR, ALU_OPRN_NOR, ALU_OPRN_SLT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way round-robin arbiter with priority advance on grant
module rr_arb2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_adv,
   output logic o_gnt0,
   output logic o_gnt1
);

   logic r_pri;

   // After a grant, priority moves to the requester that was not served
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_pri <= 1'b0;
      else if (i_adv)
         r_pri <= o_gnt0;
   end

   assign o_gnt0 = i_valid0 & (~i_valid1 | ~r_pri);
   assign o_gnt1 = i_valid1 & (~i_valid0 |  r_pri);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters, multicycle MUL hold
// Optional grant counters enabled by ALU_ARB_STATS_EN.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = ALU_DATA_WIDTH,
   parameter int OPRN_WIDTH = ALU_OPRN_WIDTH,
   parameter int MUL_CYCLES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req0_valid,
   output logic                  o_req0_ready,
   input  logic [DATA_WIDTH-1:0] i_req0_op1,
   input  logic [DATA_WIDTH-1:0] i_req0_op2,
   input  logic [OPRN_WIDTH-1:0] i_req0_oprn,
   input  logic                  i_req1_valid,
   output logic                  o_req1_ready,
   input  logic [DATA_WIDTH-1:0] i_req1_op1,
   input  logic [DATA_WIDTH-1:0] i_req1_op2,
   input  logic [OPRN_WIDTH-1:0] i_req1_oprn,
   output logic                  o_rsp0_valid,
   input  logic                  i_rsp0_ready,
   output logic [DATA_WIDTH-1:0] o_rsp0_data,
   output logic                  o_rsp0_zero,
   output logic                  o_rsp0_err,
   output logic                  o_rsp1_valid,
   input  logic                  i_rsp1_ready,
   output logic [DATA_WIDTH-1:0] o_rsp1_data,
   output logic                  o_rsp1_zero,
   output logic                  o_rsp1_err,
   output logic [DATA_WIDTH-1:0] o_alu_op1,
   output logic [DATA_WIDTH-1:0] o_alu_op2,
   output logic [OPRN_WIDTH-1:0] o_alu_oprn,
   input  logic [DATA_WIDTH-1:0] i_alu_out,
   input  logic                  i_alu_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]           o_gnt_cnt0,
   output logic [15:0]           o_gnt_cnt1
`endif
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES - 1);

   alu_arb_state_e r_state, w_state_nxt;
   logic                  r_owner;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_alu_op1, r_alu_op2, r_data;
   logic [OPRN_WIDTH-1:0] r_alu_oprn;
   logic                  r_zero, r_err;

   logic                  w_gnt0, w_gnt1, w_idle, w_acc0, w_acc1, w_acc, w_legal, w_rsp_take;
   logic [DATA_WIDTH-1:0] w_sel_op1, w_sel_op2;
   logic [OPRN_WIDTH-1:0] w_sel_oprn;

   rr_arb2 u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid0 (i_req0_valid),
      .i_valid1 (i_req1_valid),
      .i_adv    (w_acc),
      .o_gnt0   (w_gnt0),
      .o_gnt1   (w_gnt1)
   );

   assign w_idle     = (r_state == ST_IDLE);
   assign w_acc0     = w_idle & w_gnt0;
   assign w_acc1     = w_idle & w_gnt1;
   assign w_acc      = w_acc0 | w_acc1;
   assign w_sel_op1  = w_acc1 ? i_req1_op1  : i_req0_op1;
   assign w_sel_op2  = w_acc1 ? i_req1_op2  : i_req0_op2;
   assign w_sel_oprn = w_acc1 ? i_req1_oprn : i_req0_oprn;
   assign w_legal    = alu_oprn_legal(w_sel_oprn);
   assign w_rsp_take = r_owner ? i_rsp1_ready : i_rsp0_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      o_rsp0_valid = 1'b0;
      o_rsp1_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_req0_ready = w_gnt0;
            o_req1_ready = w_gnt1;
            if (w_acc)
               w_state_nxt = w_legal ? ST_EXEC : ST_RESP;
         end
         ST_EXEC: begin
            if (r_cnt == '0)
               w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            o_rsp0_valid = ~r_owner;
            o_rsp1_valid = r_owner;
            if (w_rsp_take)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ALU inputs only move on a legal accept, so an illegal op leaves them untouched
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner    <= 1'b0;
         r_cnt      <= '0;
         r_alu_op1  <= '0;
         r_alu_op2  <= '0;
         r_alu_oprn <= '0;
         r_data     <= '0;
         r_zero     <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_acc) begin
         r_owner <= w_acc1;
         if (w_legal) begin
            r_alu_op1  <= w_sel_op1;
            r_alu_op2  <= w_sel_op2;
            r_alu_oprn <= w_sel_oprn;
            r_cnt      <= (w_sel_oprn == ALU_OPRN_MUL) ? CNT_MUL : '0;
         end else begin
            r_data <= '0;
            r_zero <= 1'b0;
            r_err  <= 1'b1;
         end
      end else if (r_state == ST_EXEC) begin
         if (r_cnt == '0) begin
            r_data <= i_alu_out;
            r_zero <= i_alu_zero;
            r_err  <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_alu_op1   = r_alu_op1;
   assign o_alu_op2   = r_alu_op2;
   assign o_alu_oprn  = r_alu_oprn;
   assign o_rsp0_data = r_data;
   assign o_rsp1_data = r_data;
   assign o_rsp0_zero = r_zero;
   assign o_rsp1_zero = r_zero;
   assign o_rsp0_err  = r_err;
   assign o_rsp1_err  = r_err;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] r_gnt_cnt0, r_gnt_cnt1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gnt_cnt0 <= '0;
         r_gnt_cnt1 <= '0;
      end else begin
         if (w_acc0 && (r_gnt_cnt0 != 16'hFFFF))
            r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
         if (w_acc1 && (r_gnt_cnt1 != 16'hFFFF))
            r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
      end
   end

   assign o_gnt_cnt0 = r_gnt_cnt0;
   assign o_gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule
